// File: rtl/prox_sched_defs.sv
// Shared constants for the proximity scan scheduler: state encodings,
// default parameter values and a sizing helper.
package prox_sched_defs;

    localparam int DEF_NUM_SENSORS   = 4;
    localparam int DEF_SETTLE_CYCLES = 1200;
    localparam int DEF_SAMPLE_CYCLES = 8;
    localparam int DEF_GAP_CYCLES    = 12000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_STORE  = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/prox_sync2.sv
// Multi-bit two-flop synchronizer; resets to all-ones, the inactive level
// of the active-low sensor outputs.
module prox_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the asynchronous inputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta_r <= '1;
            sync_r <= '1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/proximity_scan_scheduler.sv
// Time-multiplexed proximity sensor scanner: settles each emitter, samples
// its synchronized output, and latches a majority-low detection bitmap.
module proximity_scan_scheduler
    import prox_sched_defs::*;
#(
    parameter int NUM_SENSORS   = DEF_NUM_SENSORS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   scan_en,
    input  logic [NUM_SENSORS-1:0] pin,
    output logic [NUM_SENSORS-1:0] en,
    output logic [NUM_SENSORS-1:0] led,
    output logic                   busy,
    output logic                   scan_done
);

    localparam int CW = $clog2(max3(SETTLE_CYCLES, SAMPLE_CYCLES, GAP_CYCLES)) + 1;
    localparam int IW = $clog2(NUM_SENSORS);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_HALF = CW'(SAMPLE_CYCLES / 2);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_SENSORS - 1);

    logic [NUM_SENSORS-1:0] pin_sync_s;
    logic                   pin_low_s;
    logic [CW-1:0]          low_next_s;

    state_t                 state_r;
    logic [IW-1:0]          idx_r;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          low_r;
    logic [NUM_SENSORS-1:0] led_r;

    prox_sync2 #(.WIDTH(NUM_SENSORS)) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (pin),
        .q    (pin_sync_s)
    );

    assign pin_low_s  = ~pin_sync_s[idx_r];
    assign low_next_s = low_r + {{(CW-1){1'b0}}, pin_low_s};

    // Scan sequencer: state, sensor index, cycle/low counters and detection latch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            low_r   <= '0;
            led_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_r <= '0;
                    cnt_r <= '0;
                    low_r <= '0;
                    if (scan_en) state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_r <= ST_SAMPLE;
                        cnt_r   <= '0;
                        low_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    low_r <= low_next_s;
                    if (cnt_r == SAMPLE_LAST) begin
                        state_r <= ST_STORE;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_STORE: begin
                    // A tie between low and high samples counts as no obstacle.
                    led_r[idx_r] <= (low_r > SAMPLE_HALF);
                    cnt_r        <= '0;
                    if (idx_r == IDX_LAST) begin
                        idx_r   <= '0;
                        state_r <= ST_GAP;
                    end else begin
                        idx_r   <= idx_r + IW'(1);
                        state_r <= ST_SETTLE;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        cnt_r   <= '0;
                        state_r <= scan_en ? ST_SETTLE : ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= '0;
                    cnt_r   <= '0;
                    low_r   <= '0;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        en        = '0;
        busy      = 1'b0;
        scan_done = 1'b0;
        if ((state_r == ST_SETTLE) || (state_r == ST_SAMPLE)) begin
            en[idx_r] = 1'b1;
        end else begin
            en = '0;
        end
        busy      = (state_r != ST_IDLE);
        scan_done = (state_r == ST_STORE) && (idx_r == IDX_LAST);
    end

    assign led = led_r;

endmodule

// File: tb/tb_proximity_scan_scheduler.sv
// Self-checking bench: a position-in-scan model predicts every output each
// cycle, and directed scans pin the model with hand-computed values.
module tb_proximity_scan_scheduler;
    import prox_sched_defs::*;

    localparam int N      = DEF_NUM_SENSORS;
    localparam int SET    = 4;
    localparam int SAM    = 4;
    localparam int GAP    = 2;
    localparam int SLOT   = SET + SAM + 1;
    localparam int SCAN   = N * SLOT;
    localparam int PERIOD = SCAN + GAP;

    logic         clk = 1'b0;
    logic         rstn;
    logic         scan_en;
    logic [N-1:0] pin;
    logic [N-1:0] en;
    logic [N-1:0] led;
    logic         busy;
    logic         scan_done;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    logic prev_done = 1'b0;

    // Model state
    bit           m_active = 1'b0;
    int           m_pos    = 0;
    logic [N-1:0] m_led    = '0;
    logic [N-1:0] s1       = '1;
    logic [N-1:0] s2       = '1;
    int           lowc     = 0;
    int           mk, mr;

    // Per-cycle observations recorded by run_scan
    logic [N-1:0] obs_en   [0:79];
    logic [N-1:0] obs_led  [0:79];
    logic         obs_busy [0:79];
    logic         obs_done [0:79];

    proximity_scan_scheduler #(
        .NUM_SENSORS   (N),
        .SETTLE_CYCLES (SET),
        .SAMPLE_CYCLES (SAM),
        .GAP_CYCLES    (GAP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .scan_en   (scan_en),
        .pin       (pin),
        .en        (en),
        .led       (led),
        .busy      (busy),
        .scan_done (scan_done)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_en();
        logic [N-1:0] v;
        v = '0;
        if (m_active && m_pos < SCAN && (m_pos % SLOT) < SET + SAM)
            v[m_pos / SLOT] = 1'b1;
        return v;
    endfunction

    // Behavioural model: tracks position within the scan period.
    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_led    = '0;
            s1       = '1;
            s2       = '1;
            lowc     = 0;
        end else begin
            if (m_active && m_pos < SCAN) begin
                mk = m_pos / SLOT;
                mr = m_pos % SLOT;
                if (mr >= SET && mr < SET + SAM && !s2[mk]) lowc++;
                if (mr == SLOT - 1) begin
                    m_led[mk] = (lowc > SAM / 2);
                    lowc = 0;
                end
            end
            if (!m_active) begin
                if (scan_en) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == PERIOD - 1) begin
                if (scan_en) m_pos = 0;
                else m_active = 1'b0;
            end else begin
                m_pos++;
            end
            s2 = s1;
            s1 = pin;
        end
    end

    // Cycle-by-cycle compare against the model plus one-hot / single-pulse rules.
    always @(negedge clk) begin
        if (chk_on) begin
            check("en",         en,        model_en());
            check("led",        led,       m_led);
            check("busy",       busy,      m_active);
            check("scan_done",  scan_done, m_active && (m_pos == SCAN - 1));
            check("en_onehot0", ($countones(en) <= 1), 1);
            check("done_twice", prev_done && scan_done, 0);
        end
        prev_done <= scan_done;
    end

    task automatic run_scan(input logic [N-1:0] base, input int lo_bit, input int lo_start,
                            input int lo_end, input int drop_pos, input int rst_pos, input int len);
        int w;
        pin     = base;
        scan_en = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!busy && w < 10);
        check("scan_start", busy, 1);
        for (int p = 0; p < len; p++) begin
            obs_en[p]   = en;
            obs_led[p]  = led;
            obs_busy[p] = busy;
            obs_done[p] = scan_done;
            pin = base;
            if (p >= lo_start && p < lo_end) pin[lo_bit] = 1'b0;
            if (p == drop_pos) scan_en = 1'b0;
            rstn = (p == rst_pos) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rstn    = 1'b1;
        scan_en = 1'b0;
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("idle_reached", busy, 0);
    endtask

    function automatic int count_done(input int from, input int to);
        int n;
        n = 0;
        for (int p = from; p <= to; p++) if (obs_done[p]) n++;
        return n;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        rstn    = 1'b0;
        scan_en = 1'b0;
        pin     = '1;
        @(negedge clk);
        chk_on = 1'b1;
        check("rst_en",   en,        0);
        check("rst_led",  led,       0);
        check("rst_busy", busy,      0);
        check("rst_done", scan_done, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_en", busy, 0);

        // All sensors clear: emitter walk and scan length
        run_scan(4'b1111, 0, 0, 0, 36, -1, 40);
        check("walk_s0",  obs_en[0],  4'b0001);
        check("walk_s0e", obs_en[7],  4'b0001);
        check("store_s0", obs_en[8],  4'b0000);
        check("walk_s1",  obs_en[9],  4'b0010);
        check("walk_s2",  obs_en[18], 4'b0100);
        check("walk_s3",  obs_en[27], 4'b1000);
        check("store_s3", obs_en[35], 4'b0000);
        first_done = -1;
        for (int p = 0; p < 40; p++) if (obs_done[p] && first_done < 0) first_done = p;
        check("done_latency", first_done, 35);
        check("s1_led", obs_led[39], 4'b0000);
        check("s1_ndone", count_done(0, 39), 1);

        // Obstacle on sensor 2, held across idle
        run_scan(4'b1011, 0, 0, 0, 36, -1, 40);
        check("s2_led", obs_led[39], 4'b0100);
        repeat (20) @(negedge clk);
        check("s2_led_idle",  led,  4'b0100);
        check("s2_busy_idle", busy, 0);

        // Sensor 1 low for 3 of 4 samples, then exactly 2 of 4 (tie)
        run_scan(4'b1111, 1, 11, 14, 36, -1, 40);
        check("three_of_four", obs_led[39], 4'b0010);
        run_scan(4'b1111, 1, 11, 13, 36, -1, 40);
        check("tie", obs_led[39], 4'b0000);

        // scan_en dropped during sensor 1 settle
        run_scan(4'b1111, 0, 0, 0, 10, -1, 46);
        check("drop_done_pos", obs_done[35], 1);
        check("drop_ndone",    count_done(0, 45), 1);
        check("drop_gap1",     obs_busy[36], 1);
        check("drop_gap2",     obs_busy[37], 1);
        check("drop_idle",     obs_busy[38], 0);

        // Reset during sensor 2 sample, then a fresh scan
        run_scan(4'b1110, 0, 0, 0, 30, 23, 66);
        check("pre_rst_led",   obs_led[22],  4'b0001);
        check("rst_mid_en",    obs_en[24],   4'b0000);
        check("rst_mid_led",   obs_led[24],  4'b0000);
        check("rst_mid_busy",  obs_busy[24], 0);
        check("rst_mid_ndone", count_done(0, 24), 0);
        check("restart_en",    obs_en[25],   4'b0001);
        check("restart_busy",  obs_busy[25], 1);
        check("restart_done",  obs_done[60], 1);
        check("restart_led",   obs_led[65],  4'b0001);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proximity_scan_scheduler.md
PROXIMITY_SCAN_SCHEDULER -- requirements
Module: proximity_scan_scheduler

Interface
REQ-001 SHALL have parameter NUM_SENSORS, default 4: number of time-multiplexed proximity sensors (2..8).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1200: emitter-on settle time in clk cycles (100 us at 12 MHz).
REQ-003 SHALL have parameter SAMPLE_CYCLES, default 8: sampling-window length in cycles; must be even and at least 2.
REQ-004 SHALL have parameter GAP_CYCLES, default 12000: idle time between consecutive scans.
REQ-005 SHALL have port clk, input, 1 bit: single system clock.
REQ-006 SHALL have port rstn, input, 1 bit: reset, synchronous to clk, active-low.
REQ-007 SHALL have port scan_en, input, 1 bit: level request for continuous scanning.
REQ-008 SHALL have port pin, input, NUM_SENSORS bits: asynchronous sensor outputs, active-low meaning obstacle present.
REQ-009 SHALL have port en, output, NUM_SENSORS bits: per-sensor emitter enable, one-hot or zero.
REQ-010 SHALL have port led, output, NUM_SENSORS bits: latched detection bitmap, 1 meaning obstacle present.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 SHALL have port scan_done, output, 1 bit: one-cycle pulse at the end of each full scan.

Function
REQ-013 SHALL pass each pin bit through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-014 SHALL implement FSM states IDLE, SETTLE, SAMPLE, STORE and GAP.
REQ-015 SHALL, in IDLE with scan_en=1 at a clk edge, enter SETTLE with idx=0, driving en=one-hot(idx) from the next cycle.
REQ-016 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles, then enter SAMPLE with the low-sample counter cleared.
REQ-017 SHALL, in SAMPLE, count cycles where synchronized pin[idx]=0, over exactly SAMPLE_CYCLES cycles, then enter STORE.
REQ-018 SHALL, in STORE, set led[idx]=1 if the low count is strictly greater than SAMPLE_CYCLES/2, else 0 (a tie gives 0); other led bits are unchanged.
REQ-019 SHALL keep en one-hot at bit idx during SETTLE and SAMPLE, and all-zero in STORE, GAP and IDLE; at most one en bit is ever high.
REQ-020 SHALL, from STORE with idx<NUM_SENSORS-1, increment idx and enter SETTLE.
REQ-021 SHALL, from STORE with idx=NUM_SENSORS-1, pulse scan_done for one cycle, wrap idx to 0 and enter GAP.
REQ-022 SHALL hold GAP for GAP_CYCLES cycles, then enter SETTLE (idx=0) if scan_en=1, else IDLE.
REQ-023 SHALL NOT abort a scan when scan_en is deasserted mid-scan; the scan completes and GAP is honoured.
REQ-024 SHALL take exactly NUM_SENSORS*(SETTLE_CYCLES+SAMPLE_CYCLES+1) cycles per scan, from the first SETTLE cycle to the scan_done cycle inclusive.
REQ-025 SHALL hold led stable between STORE updates, including across IDLE.
REQ-026 SHALL size counters to clog2 of the largest parameter plus 1, with no wrap-around inside a state.

Reset
REQ-027 SHALL, when rstn=0 at a clk edge, set state=IDLE, idx=0, all counters=0, en=0, led=0, scan_done=0, busy=0 and both synchronizer stages=1 (inactive).
REQ-028 SHALL let reset mid-scan override all activity, with no scan_done pulse and no led update.
REQ-029 SHALL, on the first edge with rstn=1, evaluate scan_en normally.

Structure
REQ-030 SHALL place FSM state encodings and default parameter values in a shared constants include (prox_sched_defs) used by the RTL and the bench.
REQ-031 SHALL instantiate sub-module prox_sync2, a NUM_SENSORS-wide 2-flop synchronizer with the same clk/rstn ports.
REQ-032 SHALL hold all other logic in one clocked process plus combinational output decode.

Verification (SETTLE_CYCLES=4, SAMPLE_CYCLES=4, GAP_CYCLES=2, NUM_SENSORS=4)
REQ-033 SHALL cover: pin=4'b1111, scan_en=1 -> en walks 0001, 0010, 0100, 1000 with each bit high for 8 cycles; scan_done fires 36 cycles after the first SETTLE cycle; led=0000.
REQ-034 SHALL cover: pin[2] held 0, others 1 -> after the first scan_done, led=4'b0100, which persists while scan_en=0 and the FSM is in IDLE.
REQ-035 SHALL cover: pin[1] low for exactly 2 of 4 synchronized sample cycles -> led[1]=0 (tie); low for 3 of 4 -> led[1]=1.
REQ-036 SHALL cover: scan_en dropped during sensor 1 SETTLE -> scan completes, scan_done pulses once, GAP of 2 cycles, then IDLE with busy=0.
REQ-037 SHALL cover: rstn=0 for 1 cycle during sensor 2 SAMPLE -> next cycle en=0, led=0, busy=0, no scan_done; with scan_en=1 a fresh scan starts at idx=0.
REQ-038 SHALL cover: a bench assertion, in every scenario, that en is never more than one-hot and scan_done is never high for 2 consecutive cycles.
